lcd_ctrl: RTL and testbench
===========================

# lcd_ctrl

- Hardware HD44780 write sequencer for the board's 16x2 character LCD.
- Sits behind the LSU's LCD I/O register path: the core hands it one byte at a time over a valid/ready handshake; the block produces the LCD bus waveforms.
- After reset it runs the power-up initialisation sequence on its own, then accepts command and data writes.
- It enforces setup, enable-pulse, hold and execution times so firmware never has to bit-bang the LCD timing.

## Interface

Parameters:

- POWERUP_CYC, 750000: idle cycles after reset before the first init write (15 ms @ 50 MHz).
- INIT_WAIT_CYC, 205000: wait after the first init function-set (4.1 ms).
- SETUP_CYC, 2: cycles RS/DATA are stable before EN rises (≥40 ns).
- EN_CYC, 25: EN high width (≥450 ns).
- HOLD_CYC, 2: cycles RS/DATA stay stable after EN falls.
- EXEC_CYC, 2500: post-write wait for normal instructions and data (≥37 µs).
- CLR_CYC, 82000: post-write wait for clear/home (≥1.52 ms).

Ports:

- i_clk, in, 1: clock.
- i_reset, in, 1: reset. One clock; reset is synchronous and active-low.
- i_valid, in, 1: write request.
- i_rs, in, 1: 0 = instruction, 1 = data.
- i_data, in, 8: byte to write.
- o_ready, out, 1: block can accept a request this cycle.
- o_init_done, out, 1: init sequence complete; sticky until reset.
- o_lcd_on, out, 1: LCD power/backlight enable.
- o_lcd_en, out, 1: LCD E strobe.
- o_lcd_rs, out, 1: LCD RS.
- o_lcd_rw, out, 1: LCD R/W; constant 0 (write-only).
- o_lcd_data, out, 8: LCD DB[7:0].

## Operation

**Reset values.** All outputs are 0 while i_reset=0: o_ready, o_init_done, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, and o_lcd_data=8'h00. o_lcd_on goes to 1 on the first cycle after reset is released.

**States.**

- PWRUP: wait POWERUP_CYC cycles, then go to SETUP with init step 0.
- IDLE: o_ready=1.
  - i_valid && o_ready captures i_rs/i_data into internal registers and moves to SETUP.
  - Input changes while not ready are ignored.
- SETUP: RS/DATA driven from the captured values, EN=0, for SETUP_CYC cycles, then PULSE.
- PULSE: EN=1 for EN_CYC cycles, then HOLD.
- HOLD: EN=0, RS/DATA held, for HOLD_CYC cycles, then WAIT.
- WAIT: down-count the selected wait.
  - If init is incomplete, advance the init step and go to SETUP.
  - Otherwise go to IDLE.

**Wait selection.**

- CLR_CYC when rs=0 and data ∈ {8'h01, 8'h02, 8'h03} (clear/home).
- INIT_WAIT_CYC for init step 0.
- EXEC_CYC otherwise.

**Init sequence.** All steps are instructions (rs=0): 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06. o_init_done and o_ready rise together on the cycle IDLE is first entered.

**Data stability.** o_lcd_rs and o_lcd_data retain the last written values in IDLE. They never change while EN=1.

**Reset mid-operation.** The cycle after reset is sampled low, EN is 0 and the FSM is in PWRUP. Init re-runs in full and o_init_done clears.

**Counter.** A single down-counter of width $clog2(max of all *_CYC)+1 is shared by all states. It is loaded with N−1 on state entry, and the state exits when the counter is 0 and it is the Nth cycle. Every *_CYC parameter must be ≥1; a value of 0 is illegal (elaboration assertion).

## Timing

- **Handshake.** Acceptance occurs on the edge where i_valid && o_ready. o_ready is low in the following cycle.
- **Latency.** o_ready stays low for exactly SETUP_CYC+EN_CYC+HOLD_CYC+wait cycles after the accepting edge, then returns to 1. Back-to-back requests are therefore spaced by that amount plus one IDLE cycle.
- **EN rise.** EN rises SETUP_CYC+1 cycles after the accepting edge.
- **Outputs.** All outputs are registered; there is no combinational path from inputs to outputs. o_ready is a function of state only.

## Structure

- **lcd_pkg:** state enum (PWRUP, IDLE, SETUP, PULSE, HOLD, WAIT); init-sequence constant array and length (6); command constants CMD_FUNC_SET=8'h38, CMD_DISP_ON=8'h0C, CMD_CLEAR=8'h01, CMD_ENTRY=8'h06.
- **lcd_timer:** one sub-module, a loadable down-counter with a done flag, parameterised on width.
- FSM, capture registers and init-step counter live in lcd_ctrl.

## Test plan

All scenarios use POWERUP_CYC=20, INIT_WAIT_CYC=15, SETUP_CYC=2, EN_CYC=3, HOLD_CYC=2, EXEC_CYC=10, CLR_CYC=30.

1. Release reset → six EN pulses carrying 38, 38, 38, 0C, 01, 06 with RS=0. Each pulse is 3 cycles wide. o_init_done=o_ready=1 exactly 147 cycles after the first edge with i_reset=1.
2. After init, a single-cycle i_valid with rs=1, data=8'h41 → RS=1, DATA=41 two cycles before EN. EN is high for 3 cycles. o_ready is low for 17 cycles.
3. Instruction 8'h01 → o_ready low for 2+3+2+30=37 cycles. Instruction 8'h80 → 17 cycles.
4. i_valid held high with a new byte every cycle while busy → only bytes present on accepting edges appear on DATA. No dropped or duplicated EN pulses.
5. Reset asserted during PULSE of a data write → EN=0 and all outputs 0 next cycle. The full init sequence repeats after release.
6. Monitor over all runs: o_lcd_rw is always 0, and o_lcd_data/o_lcd_rs never change while o_lcd_en=1.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the HD44780 write sequencer.
//   - lcd_state_e : sequencer states
//   - INIT_SEQ    : power-up instruction bytes, index 0 is written first
//   - CMD_*       : HD44780 instruction bytes used by the init sequence
//   - max2 / is_clear_home : elaboration and wait-selection helpers
package lcd_pkg;

    typedef enum logic [2:0] {
        PWRUP = 3'd0,
        IDLE  = 3'd1,
        SETUP = 3'd2,
        PULSE = 3'd3,
        HOLD  = 3'd4,
        WAIT  = 3'd5
    } lcd_state_e;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift

    localparam int INIT_LEN = 6;
    localparam int STEP_W   = 3;

    // Element [0] is the lowest byte, i.e. the last one in this list.
    localparam logic [INIT_LEN-1:0][7:0] INIT_SEQ = {
        CMD_ENTRY, CMD_CLEAR, CMD_DISP_ON, CMD_FUNC_SET, CMD_FUNC_SET, CMD_FUNC_SET
    };

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clear display (01) and return home (02/03) need the long execution time.
    function automatic logic is_clear_home(input logic rs, input logic [7:0] data);
        return (rs == 1'b0) && (data == 8'h01 || data == 8'h02 || data == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// lcd_timer: loadable down-counter shared by every sequencer state.
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset, loads RESET_VAL
//   load_i  : load value_i this cycle (takes priority over counting)
//   value_i : load value, N-1 for an N-cycle interval
//   done_o  : count has reached zero (last cycle of the interval)
module lcd_timer #(
    parameter int             W         = 8,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= RESET_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 write sequencer for a 16x2 character LCD.
// Runs the power-up init sequence after reset, then accepts one byte per
// handshake and generates setup / enable / hold / execution timing.
//   i_clk, i_reset     : clock, synchronous active-low reset
//   i_valid, o_ready   : request handshake; a byte is taken on a clock edge
//                        where i_valid and o_ready are both 1. o_ready depends
//                        only on state, never on i_valid.
//   i_rs, i_data       : 0 = instruction / 1 = data, and the byte to write
//   o_init_done        : init sequence finished, sticky until reset
//   o_lcd_on           : LCD power / backlight enable
//   o_lcd_en/rs/rw/data: LCD bus (rw is tied low, write-only)
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC   = 750000,
    parameter int INIT_WAIT_CYC = 205000,
    parameter int SETUP_CYC     = 2,
    parameter int EN_CYC        = 25,
    parameter int HOLD_CYC      = 2,
    parameter int EXEC_CYC      = 2500,
    parameter int CLR_CYC       = 82000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_valid,
    input  logic       i_rs,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_init_done,
    output logic       o_lcd_on,
    output logic       o_lcd_en,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic [7:0] o_lcd_data
);

    localparam int MAX_CYC = max2(max2(max2(POWERUP_CYC, INIT_WAIT_CYC), max2(SETUP_CYC, EN_CYC)),
                                  max2(max2(HOLD_CYC, EXEC_CYC), CLR_CYC));
    localparam int CW = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] LD_PWR   = CW'(POWERUP_CYC - 1);
    localparam logic [CW-1:0] LD_INIT  = CW'(INIT_WAIT_CYC - 1);
    localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] LD_EN    = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] LD_EXEC  = CW'(EXEC_CYC - 1);
    localparam logic [CW-1:0] LD_CLR   = CW'(CLR_CYC - 1);

    // A zero-length interval cannot be expressed with an N-1 preload.
    if (POWERUP_CYC < 1 || INIT_WAIT_CYC < 1 || SETUP_CYC < 1 || EN_CYC < 1 ||
        HOLD_CYC < 1 || EXEC_CYC < 1 || CLR_CYC < 1) begin : g_bad_cyc
        $error("lcd_ctrl: every *_CYC parameter must be >= 1");
    end

    lcd_state_e        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [STEP_W-1:0] next_step;
    logic              rs_q, rs_d;
    logic [7:0]        data_q, data_d;
    logic              init_done_q, init_done_d;
    logic              lcd_on_q;
    logic              en_q;
    logic              ready_q;

    logic              tmr_load;
    logic [CW-1:0]     tmr_val;
    logic              tmr_done;
    logic [CW-1:0]     wait_ld;

    lcd_timer #(
        .W         (CW),
        .RESET_VAL (LD_PWR)
    ) u_timer (
        .clk_i   (i_clk),
        .rst_ni  (i_reset),
        .load_i  (tmr_load),
        .value_i (tmr_val),
        .done_o  (tmr_done)
    );

    // Execution wait for the byte currently on the bus.
    always_comb begin
        if (is_clear_home(rs_q, data_q)) begin
            wait_ld = LD_CLR;
        end else if (!init_done_q && step_q == '0) begin
            wait_ld = LD_INIT;
        end else begin
            wait_ld = LD_EXEC;
        end
    end

    assign next_step = step_q + 1'b1;

    // Every transition preloads the timer with the next state's length - 1.
    // RS/DATA only change on PWRUP->SETUP, IDLE->SETUP or WAIT->SETUP, so they
    // are stable across the whole SETUP/PULSE/HOLD window.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        rs_d        = rs_q;
        data_d      = data_q;
        init_done_d = init_done_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        case (state_q)
            PWRUP: begin
                if (tmr_done) begin
                    state_d  = SETUP;
                    step_d   = '0;
                    rs_d     = 1'b0;
                    data_d   = INIT_SEQ[0];
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETUP;
                end
            end
            IDLE: begin
                if (i_valid) begin
                    state_d  = SETUP;
                    rs_d     = i_rs;
                    data_d   = i_data;
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETUP;
                end
            end
            SETUP: begin
                if (tmr_done) begin
                    state_d  = PULSE;
                    tmr_load = 1'b1;
                    tmr_val  = LD_EN;
                end
            end
            PULSE: begin
                if (tmr_done) begin
                    state_d  = HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = LD_HOLD;
                end
            end
            HOLD: begin
                if (tmr_done) begin
                    state_d  = WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = wait_ld;
                end
            end
            WAIT: begin
                if (tmr_done) begin
                    if (!init_done_q && step_q != STEP_W'(INIT_LEN - 1)) begin
                        state_d  = SETUP;
                        step_d   = next_step;
                        rs_d     = 1'b0;
                        data_d   = INIT_SEQ[next_step];
                        tmr_load = 1'b1;
                        tmr_val  = LD_SETUP;
                    end else begin
                        state_d     = IDLE;
                        init_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = PWRUP;
                tmr_load = 1'b1;
                tmr_val  = LD_PWR;
            end
        endcase
    end

    // EN and READY are registered from the next state so they change on the
    // same edge as the state itself.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q     <= PWRUP;
            step_q      <= '0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            init_done_q <= 1'b0;
            lcd_on_q    <= 1'b0;
            en_q        <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            init_done_q <= init_done_d;
            lcd_on_q    <= 1'b1;
            en_q        <= (state_d == PULSE);
            ready_q     <= (state_d == IDLE);
        end
    end

    assign o_ready     = ready_q;
    assign o_init_done = init_done_q;
    assign o_lcd_on    = lcd_on_q;
    assign o_lcd_en    = en_q;
    assign o_lcd_rs    = rs_q;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_data  = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
module tb_lcd_ctrl;

  localparam int P_PWR = 20;
  localparam int P_IW  = 15;
  localparam int P_S   = 2;
  localparam int P_E   = 3;
  localparam int P_H   = 2;
  localparam int P_EX  = 10;
  localparam int P_CLR = 30;

  localparam logic [7:0] INIT_BYTES [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       i_valid = 1'b0;
  logic       i_rs = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       o_ready, o_init_done, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw;
  logic [7:0] o_lcd_data;

  lcd_ctrl #(
    .POWERUP_CYC   (P_PWR),
    .INIT_WAIT_CYC (P_IW),
    .SETUP_CYC     (P_S),
    .EN_CYC        (P_E),
    .HOLD_CYC      (P_H),
    .EXEC_CYC      (P_EX),
    .CLR_CYC       (P_CLR)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_valid     (i_valid),
    .i_rs        (i_rs),
    .i_data      (i_data),
    .o_ready     (o_ready),
    .o_init_done (o_init_done),
    .o_lcd_on    (o_lcd_on),
    .o_lcd_en    (o_lcd_en),
    .o_lcd_rs    (o_lcd_rs),
    .o_lcd_rw    (o_lcd_rw),
    .o_lcd_data  (o_lcd_data)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each write is a window of S+E+H+wait cycles counted from the edge that
  // starts it; EN is high in cycles S+1..S+E of that window.
  logic [8:0] exp_q[$];
  logic       m_valid = 1'b0;
  logic       m_on, m_ready, m_done, m_en, m_rs, m_pwr;
  logic [7:0] m_data;
  int         m_step, m_k, m_len;

  task automatic model_start(input logic rs, input logic [7:0] d);
    int w;
    if (rs == 1'b0 && d >= 8'h01 && d <= 8'h03) w = P_CLR;
    else if (!m_done && m_step == 0) w = P_IW;
    else w = P_EX;
    m_rs   = rs;
    m_data = d;
    m_k    = 1;
    m_len  = P_S + P_E + P_H + w;
    exp_q.push_back({rs, d});
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b1;
      m_on = 0; m_ready = 0; m_done = 0; m_en = 0; m_rs = 0; m_data = 8'h00;
      m_pwr = 1; m_step = 0; m_k = 1; m_len = P_PWR;
      exp_q.delete();
    end else begin
      m_on = 1;
      if (m_ready) begin
        if (i_valid) begin
          m_ready = 0;
          model_start(i_rs, i_data);
        end
      end else begin
        m_k++;
        if (m_k > m_len) begin
          if (m_pwr) begin
            m_pwr = 0;
            m_step = 0;
            model_start(1'b0, INIT_BYTES[0]);
          end else if (!m_done && m_step < 5) begin
            m_step++;
            model_start(1'b0, INIT_BYTES[m_step]);
          end else begin
            m_done = 1;
            m_ready = 1;
          end
        end
      end
      m_en = !m_ready && !m_pwr && (m_k > P_S) && (m_k <= P_S + P_E);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("ready", o_ready, m_ready);
      check("init_done", o_init_done, m_done);
      check("lcd_on", o_lcd_on, m_on);
      check("lcd_en", o_lcd_en, m_en);
      check("lcd_rs", o_lcd_rs, m_rs);
      check("lcd_data", o_lcd_data, m_data);
      check("lcd_rw", o_lcd_rw, 1'b0);
    end
  end

  // ---------------- bus monitor / scoreboard ----------------
  logic [7:0] cap_q[$];
  int         mon_w = 0;
  logic       mon_prev_en = 1'b0;
  logic       mon_prev_rs = 1'b0;
  logic [7:0] mon_prev_data = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_w = 0;
      mon_prev_en = 1'b0;
    end else begin
      if (o_lcd_en && !mon_prev_en) begin
        cap_q.push_back(o_lcd_data);
        if (exp_q.size() == 0) begin
          check("sb_unexpected_pulse", 1, 0);
        end else begin
          check("sb_byte", {o_lcd_rs, o_lcd_data}, exp_q.pop_front());
        end
      end
      if (o_lcd_en && mon_prev_en) begin
        check("stable_rs", o_lcd_rs, mon_prev_rs);
        check("stable_data", o_lcd_data, mon_prev_data);
      end
      if (o_lcd_en) begin
        mon_w++;
      end else if (mon_prev_en) begin
        check("en_width", mon_w, P_E);
        mon_w = 0;
      end
      mon_prev_en = o_lcd_en;
      mon_prev_rs = o_lcd_rs;
      mon_prev_data = o_lcd_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int k = 0;
    while (!o_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!o_ready) check("ready_timeout", 0, 1);
  endtask

  // Called on a negedge just after rst_n has been raised; returns the cycle
  // number (1 = cycle after the first edge with reset high) of init_done.
  task automatic measure_init(output int cyc);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!o_init_done && k < 1000);
    cyc = k;
  endtask

  task automatic check_init_bytes();
    check("init_pulse_count", cap_q.size(), 6);
    for (int i = 0; i < 6 && i < cap_q.size(); i++) begin
      check("init_byte", cap_q[i], INIT_BYTES[i]);
    end
  endtask

  // low = cycles with o_ready low after the accepting edge,
  // first_en = cycle index of the first EN-high cycle.
  task automatic send(input logic rs, input logic [7:0] d, output int low, output int first_en);
    int k;
    wait_ready();
    i_valid = 1'b1;
    i_rs = rs;
    i_data = d;
    @(negedge clk);
    i_valid = 1'b0;
    i_rs = 1'($urandom_range(0, 1));
    i_data = 8'($urandom);
    low = 0;
    first_en = 0;
    k = 1;
    while (!o_ready && k < 600) begin
      if (o_lcd_en && first_en == 0) first_en = k;
      low++;
      @(negedge clk);
      k++;
    end
    if (!o_ready) check("send_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc, low, fe, k;

    repeat (3) @(negedge clk);
    check("rst_ready", o_ready, 1'b0);
    check("rst_init_done", o_init_done, 1'b0);
    check("rst_lcd_on", o_lcd_on, 1'b0);
    check("rst_lcd_data", o_lcd_data, 8'h00);

    // power-up init
    rst_n = 1'b1;
    measure_init(cyc);
    check("init_latency", cyc, 147);
    check("init_ready", o_ready, 1'b1);
    check_init_bytes();

    // single data write and instruction latencies
    send(1'b1, 8'h41, low, fe);
    check("lat_data_41", low, 17);
    check("en_rise_41", fe, 3);
    send(1'b0, 8'h01, low, fe);
    check("lat_clear", low, 37);
    send(1'b0, 8'h80, low, fe);
    check("lat_ddram", low, 17);
    send(1'b0, 8'h02, low, fe);
    check("lat_home", low, 37);

    // random writes with random idle gaps
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), low, fe);
    end

    // valid held high, new byte every cycle
    for (int i = 0; i < 90; i++) begin
      i_valid = 1'b1;
      i_rs = 1'($urandom_range(0, 1));
      i_data = 8'($urandom);
      @(negedge clk);
    end
    i_valid = 1'b0;
    wait_ready();

    // reset during the EN pulse of a data write
    i_valid = 1'b1;
    i_rs = 1'b1;
    i_data = 8'h5A;
    @(negedge clk);
    i_valid = 1'b0;
    k = 0;
    while (!o_lcd_en && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!o_lcd_en) check("pulse_timeout", 0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_en", o_lcd_en, 1'b0);
    check("mid_rst_ready", o_ready, 1'b0);
    check("mid_rst_init_done", o_init_done, 1'b0);
    check("mid_rst_lcd_on", o_lcd_on, 1'b0);
    check("mid_rst_rs", o_lcd_rs, 1'b0);
    check("mid_rst_data", o_lcd_data, 8'h00);
    @(negedge clk);
    cap_q.delete();
    rst_n = 1'b1;
    measure_init(cyc);
    check("reinit_latency", cyc, 147);
    check_init_bytes();

    send(1'b1, 8'h7E, low, fe);
    check("lat_after_reinit", low, 17);
    wait_ready();
    repeat (2) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
